// File: rtl/mfp_multi_digit_seven_segment_scanner_if.sv
// Bundle between the system-side display bus and the multiplexed seven-segment scanner.
interface mfp_multi_digit_seven_segment_scanner_if #(
  parameter int unsigned N_DIGITS = 8,
  parameter int unsigned PWM_BITS = 4
);
  logic [4*N_DIGITS-1:0] number;
  logic [N_DIGITS-1:0]   dots;
  logic [N_DIGITS-1:0]   digit_en;
  logic                  blank_lz;
  logic [PWM_BITS-1:0]   brightness;
  logic [6:0]            seg;
  logic                  dp;
  logic [N_DIGITS-1:0]   anode;
  logic                  frame_start;

  modport master (
    output number, dots, digit_en, blank_lz, brightness,
    input  seg, dp, anode, frame_start
  );

  modport slave (
    input  number, dots, digit_en, blank_lz, brightness,
    output seg, dp, anode, frame_start
  );
endinterface

// File: rtl/mfp_multi_digit_seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with frame snapshots,
// per-digit enables, leading-zero blanking and PWM brightness.
module mfp_multi_digit_seven_segment_scanner #(
  parameter int unsigned N_DIGITS       = 8,
  parameter int unsigned DIGIT_PERIOD   = 50000,
  parameter int unsigned PWM_BITS       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input logic clk,
  input logic rst,
  mfp_multi_digit_seven_segment_scanner_if.slave bus
);

  localparam int unsigned CNT_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned STEP  = DIGIT_PERIOD >> PWM_BITS;

  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIGIT_PERIOD - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF  = {7{SEG_ACTIVE_LOW}};
  localparam logic                DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{DIG_ACTIVE_LOW}};

  logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*N_DIGITS-1:0] num_q, num_d;
  logic [N_DIGITS-1:0]   dots_q, dots_d;
  logic [N_DIGITS-1:0]   en_q, en_d;
  logic                  blz_q, blz_d;
  logic [PWM_BITS-1:0]   br_q, br_d;
  logic                  fs_q, fs_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [N_DIGITS-1:0]   anode_q, anode_d;

  logic                  snap_c;
  logic                  zero_run_c;
  logic [N_DIGITS-1:0]   lz_c;
  logic [3:0]            cur_nib_c;
  logic                  cur_dot_c;
  logic                  cur_en_c;
  logic                  cur_lz_c;
  logic [31:0]           thresh_c;
  logic                  pwm_ok_c;
  logic                  lit_c;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  endfunction

  // State register: scan counters, frame snapshot and registered pin drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt_q <= '0;
      idx_q      <= '0;
      num_q      <= '0;
      dots_q     <= '0;
      en_q       <= '0;
      blz_q      <= 1'b0;
      br_q       <= '0;
      fs_q       <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      anode_q    <= AN_OFF;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
      num_q      <= num_d;
      dots_q     <= dots_d;
      en_q       <= en_d;
      blz_q      <= blz_d;
      br_q       <= br_d;
      fs_q       <= fs_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      anode_q    <= anode_d;
    end
  end

  // Next state: slot counter, digit index and frame snapshot capture.
  always_comb begin
    slot_cnt_d = slot_cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_cnt_q == CNT_LAST) begin
      slot_cnt_d = '0;
      idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    snap_c = (slot_cnt_q == '0) && (idx_q == '0);
    num_d  = snap_c ? bus.number     : num_q;
    dots_d = snap_c ? bus.dots       : dots_q;
    en_d   = snap_c ? bus.digit_en   : en_q;
    blz_d  = snap_c ? bus.blank_lz   : blz_q;
    br_d   = snap_c ? bus.brightness : br_q;
  end

  // Digit i is blanked when every nibble from i up to the top is zero; digit 0 never is.
  always_comb begin
    lz_c       = '0;
    zero_run_c = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      zero_run_c = zero_run_c & (num_q[4*i +: 4] == 4'h0);
      lz_c[i]    = blz_q & zero_run_c & (i > 0);
    end
  end

  // Output logic: select the current digit, apply PWM and ghost gap, then polarity.
  always_comb begin
    cur_nib_c = 4'h0;
    cur_dot_c = 1'b0;
    cur_en_c  = 1'b0;
    cur_lz_c  = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib_c = num_q[4*i +: 4];
        cur_dot_c = dots_q[i];
        cur_en_c  = en_q[i];
        cur_lz_c  = lz_c[i];
      end
    end
    thresh_c = 32'(br_q) * STEP;
    pwm_ok_c = (&br_q) || (32'(slot_cnt_q) < thresh_c);
    lit_c    = (slot_cnt_q != '0) && cur_en_c && !cur_lz_c && pwm_ok_c;

    seg_d   = SEG_OFF;
    dp_d    = DP_OFF;
    anode_d = AN_OFF;
    if (lit_c) begin
      seg_d   = glyph(cur_nib_c) ^ SEG_OFF;
      dp_d    = cur_dot_c ^ DP_OFF;
      anode_d = (N_DIGITS'(1) << idx_q) ^ AN_OFF;
    end
    fs_d = snap_c;
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.anode       = anode_q;
  assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_mfp_multi_digit_seven_segment_scanner.sv
// Self-checking bench for the seven-segment scanner: 4 digits, 16-cycle slots, 2-bit PWM.
module tb_mfp_multi_digit_seven_segment_scanner;

  typedef struct packed {
    logic [3:0] anode;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  obs_t sb[$];

  int         m_cyc = 0;
  logic [15:0] m_num = '0;
  logic [3:0]  m_dots = '0;
  logic [3:0]  m_en = '0;
  logic        m_blz = 1'b0;
  logic [1:0]  m_br = '0;

  logic [6:0] glyph_tb [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  mfp_multi_digit_seven_segment_scanner_if #(.N_DIGITS(4), .PWM_BITS(2)) bus ();

  mfp_multi_digit_seven_segment_scanner #(
    .N_DIGITS(4), .DIGIT_PERIOD(16), .PWM_BITS(2),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: predicts the outputs of the coming edge from frame-relative cycle count.
  task automatic tick();
    obs_t e;
    int   d, s, hi;
    logic lit;
    e = '{anode: 4'hF, seg: 7'h7F, dp: 1'b1, fs: 1'b0};
    if (rst) begin
      m_cyc = 0; m_num = '0; m_dots = '0; m_en = '0; m_blz = 1'b0; m_br = '0;
    end else begin
      if (m_cyc == 0) begin
        m_num = bus.number; m_dots = bus.dots; m_en = bus.digit_en;
        m_blz = bus.blank_lz; m_br = bus.brightness;
        e.fs = 1'b1;
      end
      d  = m_cyc / 16;
      s  = m_cyc % 16;
      hi = -1;
      for (int i = 0; i < 4; i++) if (m_num[4*i +: 4] != 4'h0) hi = i;
      lit = (s != 0) && m_en[d] && !(m_blz && d > 0 && d > hi) &&
            (m_br == 2'd3 || s < int'(m_br) * 4);
      if (lit) begin
        e.anode = ~(4'b0001 << d);
        e.seg   = ~glyph_tb[m_num[4*d +: 4]];
        e.dp    = ~m_dots[d];
      end
      m_cyc = (m_cyc + 1) % 64;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    bus.number = 16'h1234; bus.dots = 4'h0; bus.digit_en = 4'hF;
    bus.blank_lz = 1'b0; bus.brightness = 2'd3;
    for (int t = 0; t < 3; t++) begin
      tick();
      o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_sb t=%0d got=%h exp=%h", t, o, e); end
      checks++;
      if (bus.anode !== 4'hF || bus.seg !== 7'h7F || bus.frame_start !== 1'b0) begin
        errors++; $display("FAIL reset_idle an=%b seg=%b fs=%b exp an=1111 seg=1111111 fs=0",
                           bus.anode, bus.seg, bus.frame_start);
      end
    end
    rst = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL first_sb t=%0d got=%h exp=%h", t, o, e); end
      checks++;
      if (t == 0 && (bus.frame_start !== 1'b1 || bus.anode !== 4'hF)) begin
        errors++; $display("FAIL first_fs fs=%b an=%b exp fs=1 an=1111", bus.frame_start, bus.anode);
      end else if (t > 0 && (bus.anode !== 4'b1110 || bus.seg !== ~7'b1100110 ||
                             bus.frame_start !== 1'b0)) begin
        errors++; $display("FAIL first_digit0 t=%0d an=%b seg=%b exp an=1110 seg=%b",
                           t, bus.anode, bus.seg, ~7'b1100110);
      end
    end
  endtask

  task automatic test_scan();
    obs_t o, e;
    logic [3:0] exp_seq [7] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int t = 0; t < 112; t++) begin
      tick();
      o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL scan_sb t=%0d got=%h exp=%h", t, o, e); end
      checks++;
      if ($countones(~bus.anode) > 1) begin
        errors++; $display("FAIL scan_onehot an=%b exp at most one low", bus.anode);
      end
      checks++;
      if (bus.frame_start !== (t == 48)) begin
        errors++; $display("FAIL scan_fs t=%0d fs=%b exp=%b", t, bus.frame_start, t == 48);
      end
      if (t % 16 == 8) begin
        checks++;
        if (bus.anode !== exp_seq[t / 16]) begin
          errors++; $display("FAIL scan_order t=%0d an=%b exp=%b", t, bus.anode, exp_seq[t / 16]);
        end
      end
    end
  endtask

  task automatic test_lz();
    obs_t o, e;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    for (int f = 0; f < 3; f++) begin
      bus.number   = (f == 1) ? 16'h0000 : 16'h0050;
      bus.blank_lz = (f != 2);
      for (int t = 0; t < 64; t++) begin
        tick();
        o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL lz_sb f=%0d t=%0d got=%h exp=%h", f, t, o, e); end
        if (t % 16 == 8) begin
          exp_an = 4'hF; exp_seg = 7'h7F;
          if (f == 0 && t / 16 == 0) begin exp_an = 4'b1110; exp_seg = ~7'b0111111; end
          if (f == 0 && t / 16 == 1) begin exp_an = 4'b1101; exp_seg = ~7'b1101101; end
          if (f == 1 && t / 16 == 0) begin exp_an = 4'b1110; exp_seg = ~7'b0111111; end
          if (f == 2) begin
            exp_an  = ~(4'b0001 << (t / 16));
            exp_seg = (t / 16 == 1) ? ~7'b1101101 : ~7'b0111111;
          end
          checks++;
          if (bus.anode !== exp_an || bus.seg !== exp_seg) begin
            errors++; $display("FAIL lz_digit f=%0d d=%0d an=%b seg=%b exp an=%b seg=%b",
                               f, t / 16, bus.anode, bus.seg, exp_an, exp_seg);
          end
        end
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_pwm();
    obs_t o, e;
    logic [1:0] brs [3] = '{2'd1, 2'd2, 2'd0};
    int lim, s;
    logic [3:0] exp_an;
    bus.number = 16'h1234;
    for (int f = 0; f < 3; f++) begin
      bus.brightness = brs[f];
      lim = (brs[f] == 2'd1) ? 3 : (brs[f] == 2'd2) ? 7 : 0;
      for (int t = 0; t < 64; t++) begin
        tick();
        o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL pwm_sb br=%0d t=%0d got=%h exp=%h", brs[f], t, o, e); end
        s = t % 16;
        exp_an = (s >= 1 && s <= lim) ? ~(4'b0001 << (t / 16)) : 4'hF;
        checks++;
        if (bus.anode !== exp_an) begin
          errors++; $display("FAIL pwm_anode br=%0d t=%0d an=%b exp=%b", brs[f], t, bus.anode, exp_an);
        end
      end
    end
    bus.brightness = 2'd3;
  endtask

  task automatic test_snapshot();
    obs_t o, e;
    logic [6:0] exp_seg;
    bus.number = 16'h1111;
    for (int f = 0; f < 2; f++) begin
      for (int t = 0; t < 64; t++) begin
        tick();
        o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
        if (o !== e) begin errors++; $display("FAIL snap_sb f=%0d t=%0d got=%h exp=%h", f, t, o, e); end
        if (t % 16 == 8) begin
          exp_seg = (f == 0) ? ~7'b0000110 : ~7'b1011011;
          checks++;
          if (bus.seg !== exp_seg || bus.anode !== ~(4'b0001 << (t / 16))) begin
            errors++; $display("FAIL snap_digit f=%0d d=%0d seg=%b an=%b exp seg=%b",
                               f, t / 16, bus.seg, bus.anode, exp_seg);
          end
        end
        if (f == 0 && t == 40) bus.number = 16'h2222;
      end
    end
  endtask

  task automatic test_en_dots();
    obs_t o, e;
    logic [3:0] exp_an [4] = '{4'b1110, 4'hF, 4'b1011, 4'hF};
    logic       exp_dp [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bus.number = 16'h1234; bus.digit_en = 4'b0101; bus.dots = 4'b0001;
    for (int t = 0; t < 64; t++) begin
      tick();
      o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL en_sb t=%0d got=%h exp=%h", t, o, e); end
      if (t % 16 == 8) begin
        checks++;
        if (bus.anode !== exp_an[t / 16] || bus.dp !== exp_dp[t / 16]) begin
          errors++; $display("FAIL en_dots d=%0d an=%b dp=%b exp an=%b dp=%b",
                             t / 16, bus.anode, bus.dp, exp_an[t / 16], exp_dp[t / 16]);
        end
      end
    end
    bus.digit_en = 4'hF; bus.dots = 4'h0;
  endtask

  task automatic test_mid_reset();
    obs_t o, e;
    for (int t = 0; t < 24; t++) begin
      rst = (t == 20);
      tick();
      o = {bus.anode, bus.seg, bus.dp, bus.frame_start}; e = sb.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL midrst_sb t=%0d got=%h exp=%h", t, o, e); end
      if (t == 20 || t == 21) begin
        checks++;
        if (bus.anode !== 4'hF || bus.seg !== 7'h7F || bus.dp !== 1'b1 ||
            bus.frame_start !== (t == 21)) begin
          errors++; $display("FAIL midrst_state t=%0d an=%b seg=%b dp=%b fs=%b exp an=1111 fs=%b",
                             t, bus.anode, bus.seg, bus.dp, bus.frame_start, t == 21);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_pwm();
    test_snapshot();
    test_en_dots();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
